// File: rtl/axi_to_mem_pkg.sv
// Shared types for the axi_to_mem read-response path: FIFO word layouts, R beat
// layout, AXI response codes and the skid-stage state encoding.
package axi_to_mem_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned NUM_BANKS  = 2;
  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned BANK_WIDTH = DATA_WIDTH / NUM_BANKS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Packed field order puts exokay / bank_sel in the LSBs of the FIFO words.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_BANKS-1:0]  err;
    logic [NUM_BANKS-1:0]  exokay;
  } mem_resp_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic                 last;
    logic [NUM_BANKS-1:0] bank_sel;
  } r_meta_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axi_to_mem_r_merge.sv
// Combines one memory response word with its beat meta into an AXI R beat:
// unselected banks read as zero, resp folds the per-bank err/exokay flags.
module axi_to_mem_r_merge
  import axi_to_mem_pkg::*;
(
  input  mem_resp_t rsp_i,
  input  r_meta_t   meta_i,
  output r_beat_t   beat_o
);

  logic err_hit;
  logic sel_any;
  logic all_exokay;

  assign err_hit    = |(rsp_i.err & meta_i.bank_sel);
  assign sel_any    = |meta_i.bank_sel;
  assign all_exokay = &(rsp_i.exokay | ~meta_i.bank_sel);

  // NOTE: every field gets a default before the conditional writes so no latch is inferred.
  always_comb begin
    beat_o      = '0;
    beat_o.id   = meta_i.id;
    beat_o.last = meta_i.last;
    for (int b = 0; b < NUM_BANKS; b++) begin
      beat_o.data[b*BANK_WIDTH +: BANK_WIDTH] =
        meta_i.bank_sel[b] ? rsp_i.data[b*BANK_WIDTH +: BANK_WIDTH] : '0;
    end
    if (err_hit) begin
      beat_o.resp = RESP_SLVERR;
    end else if (all_exokay && sel_any) begin
      beat_o.resp = RESP_EXOKAY;
    end else begin
      beat_o.resp = RESP_OKAY;
    end
  end

endmodule

// File: rtl/axi_to_mem_r_packer.sv
// Pops paired response/meta FIFO words, merges them into AXI R beats and drives R
// through a 2-entry skid stage. Define R_PACKER_ERR_STICKY_EN for burst-sticky SLVERR.
module axi_to_mem_r_packer
  import axi_to_mem_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned NumBanks  = NUM_BANKS,
  parameter int unsigned IdWidth   = ID_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rsp_empty_i,
  input  logic [DataWidth+2*NumBanks-1:0] rsp_data_i,
  output logic                          rsp_pop_o,
  input  logic                          meta_empty_i,
  input  logic [IdWidth+NumBanks:0]     meta_i,
  output logic                          meta_pop_o,
  output logic [IdWidth-1:0]            r_id_o,
  output logic [DataWidth-1:0]          r_data_o,
  output logic [1:0]                    r_resp_o,
  output logic                          r_last_o,
  output logic                          r_valid_o,
  input  logic                          r_ready_i,
  output logic                          busy_o
);

  mem_resp_t   rsp;
  r_meta_t     meta;
  r_beat_t     merged;
  r_beat_t     beat_in;
  logic        fire;
  skid_state_e state_q, state_d;
  r_beat_t     out_q, out_d;
  r_beat_t     skid_q, skid_d;

  assign rsp  = mem_resp_t'(rsp_data_i);
  assign meta = r_meta_t'(meta_i);

  axi_to_mem_r_merge u_merge (
    .rsp_i  (rsp),
    .meta_i (meta),
    .beat_o (merged)
  );

  // Gating with rst_ni keeps both pops low while reset is held even if the FIFOs fill.
  assign fire       = rst_ni & ~rsp_empty_i & ~meta_empty_i & (state_q != ST_FULL);
  assign rsp_pop_o  = fire;
  assign meta_pop_o = fire;

`ifdef R_PACKER_ERR_STICKY_EN
  logic sticky_q, sticky_d;

  // Once a non-final beat errors, the rest of the burst (including its last beat) errors too.
  always_comb begin
    beat_in = merged;
    if (sticky_q) beat_in.resp = RESP_SLVERR;
    sticky_d = fire ? (~beat_in.last & (beat_in.resp == RESP_SLVERR)) : sticky_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sticky_q <= 1'b0;
    else         sticky_q <= sticky_d;
  end
`else
  assign beat_in = merged;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (fire) begin
          out_d   = beat_in;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (fire && r_ready_i) begin
          out_d = beat_in;
        end else if (fire) begin
          skid_d  = beat_in;
          state_d = ST_FULL;
        end else if (r_ready_i) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (r_ready_i) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign r_id_o    = out_q.id;
  assign r_data_o  = out_q.data;
  assign r_resp_o  = out_q.resp;
  assign r_last_o  = out_q.last;
  assign r_valid_o = (state_q != ST_EMPTY);
  assign busy_o    = (state_q != ST_EMPTY);

endmodule

// File: tb/tb_axi_to_mem_r_packer.sv
// Directed bench for axi_to_mem_r_packer: FIFO models feed the DUT, R handshakes
// are logged, and each step compares against hand-computed beats.
module tb_axi_to_mem_r_packer;

  localparam int DW = 64;
  localparam int NB = 2;
  localparam int IW = 4;
  localparam int RW = DW + 2*NB;
  localparam int MW = IW + 1 + NB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rsp_empty, rsp_pop, meta_empty, meta_pop;
  logic [RW-1:0] rsp_data;
  logic [MW-1:0] meta;
  logic [IW-1:0] r_id;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          r_last, r_valid, r_ready, busy;

  always #5 clk = ~clk;

  axi_to_mem_r_packer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rsp_empty_i  (rsp_empty),
    .rsp_data_i   (rsp_data),
    .rsp_pop_o    (rsp_pop),
    .meta_empty_i (meta_empty),
    .meta_i       (meta),
    .meta_pop_o   (meta_pop),
    .r_id_o       (r_id),
    .r_data_o     (r_data),
    .r_resp_o     (r_resp),
    .r_last_o     (r_last),
    .r_valid_o    (r_valid),
    .r_ready_i    (r_ready),
    .busy_o       (busy)
  );

  // FIFO models: written by the stimulus, read pointers advanced on DUT pops.
  logic [RW-1:0] rsp_mem [64];
  logic [MW-1:0] meta_mem[64];
  int rsp_wr = 0, rsp_rd = 0, meta_wr = 0, meta_rd = 0;

  assign rsp_empty  = (rsp_rd == rsp_wr);
  assign meta_empty = (meta_rd == meta_wr);
  assign rsp_data   = rsp_mem[rsp_rd];
  assign meta       = meta_mem[meta_rd];

  // R-channel log and pop timestamps.
  int            cyc = 0;
  int            got_n = 0;
  logic [IW-1:0] got_id  [64];
  logic [DW-1:0] got_data[64];
  logic [1:0]    got_resp[64];
  logic          got_last[64];
  int            got_cyc [64];
  int            pop_cyc [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rsp_pop) begin
      rsp_rd          <= rsp_rd + 1;
      pop_cyc[rsp_rd] <= cyc;
    end
    if (meta_pop) meta_rd <= meta_rd + 1;
    if (r_valid && r_ready) begin
      got_id[got_n]   <= r_id;
      got_data[got_n] <= r_data;
      got_resp[got_n] <= r_resp;
      got_last[got_n] <= r_last;
      got_cyc[got_n]  <= cyc;
      got_n           <= got_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_rsp(input logic [63:0] d, input logic [1:0] err, input logic [1:0] exo);
    rsp_mem[rsp_wr] = {d, err, exo};
    rsp_wr++;
  endtask

  task automatic push_meta(input logic [3:0] id, input logic last, input logic [1:0] sel);
    meta_mem[meta_wr] = {id, last, sel};
    meta_wr++;
  endtask

  task automatic push(input logic [3:0] id, input logic last, input logic [1:0] sel,
                      input logic [63:0] d, input logic [1:0] err, input logic [1:0] exo);
    push_rsp(d, err, exo);
    push_meta(id, last, sel);
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && got_n < n; i++) @(negedge clk);
    check(tag, 64'(got_n), 64'(n));
  endtask

  task automatic expect_beat(input string tag, input int k, input logic [3:0] id,
                             input logic [63:0] d, input logic [1:0] resp, input logic last);
    check($sformatf("%s[%0d].id", tag, k),   64'(got_id[k]),   64'(id));
    check($sformatf("%s[%0d].data", tag, k), got_data[k],      d);
    check($sformatf("%s[%0d].resp", tag, k), 64'(got_resp[k]), 64'(resp));
    check($sformatf("%s[%0d].last", tag, k), 64'(got_last[k]), 64'(last));
  endtask

  logic [1:0] sticky_exp;
  int base;
  int pops_before;

  initial begin
    rst_n   = 1'b0;
    r_ready = 1'b0;

    // Reset held with both FIFOs non-empty: nothing may pop or become valid.
    push(4'h1, 1'b1, 2'b11, 64'h0123_4567_89AB_CDEF, 2'b00, 2'b00);
    repeat (4) @(negedge clk);
    check("rst_valid", 64'(r_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_pop", 64'(rsp_pop), 64'd0);
    check("rst_meta_pop", 64'(meta_pop), 64'd0);
    check("rst_pop_count", 64'(rsp_rd), 64'd0);
    check("rst_data", r_data, 64'd0);
    check("rst_resp_id_last", 64'({r_id, r_resp, r_last}), 64'd0);
    rst_n   = 1'b1;
    r_ready = 1'b1;
    wait_beats("rst_drain_count", 1, 20);
    expect_beat("rst", 0, 4'h1, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1);

    // Streaming: 8 beats, ready held high.
    @(negedge clk);
    base = got_n;
    for (int i = 0; i < 8; i++)
      push(4'h2, (i == 7), 2'b11, 64'h1000_0000_0000_0000 + 64'(i * 64'h0101), 2'b00, 2'b00);
    wait_beats("stream_count", base + 8, 40);
    for (int i = 0; i < 8; i++)
      expect_beat("stream", base + i, 4'h2, 64'h1000_0000_0000_0000 + 64'(i * 64'h0101),
                  2'b00, (i == 7));
    check("stream_latency", 64'(got_cyc[base] - pop_cyc[base]), 64'd1);
    check("stream_back_to_back", 64'(got_cyc[base+7] - got_cyc[base]), 64'd7);
    @(negedge clk);
    check("stream_idle_busy", 64'(busy), 64'd0);

    // Backpressure: 4 beats queued, ready low for 5 cycles.
    r_ready     = 1'b0;
    base        = got_n;
    pops_before = rsp_rd;
    push(4'h3, 1'b0, 2'b11, 64'hB000_0000_0000_0000, 2'b00, 2'b00);
    push(4'h4, 1'b0, 2'b11, 64'hB111_1111_1111_1111, 2'b00, 2'b00);
    push(4'h5, 1'b0, 2'b11, 64'hB222_2222_2222_2222, 2'b00, 2'b00);
    push(4'h6, 1'b1, 2'b11, 64'hB333_3333_3333_3333, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    check("bp_hold_data_early", r_data, 64'hB000_0000_0000_0000);
    repeat (3) @(negedge clk);
    check("bp_pops", 64'(rsp_rd - pops_before), 64'd2);
    check("bp_meta_pops", 64'(meta_rd - pops_before), 64'd2);
    check("bp_valid", 64'(r_valid), 64'd1);
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_hold_data_late", r_data, 64'hB000_0000_0000_0000);
    check("bp_hold_id", 64'(r_id), 64'h3);
    check("bp_no_handshake", 64'(got_n), 64'(base));
    r_ready = 1'b1;
    wait_beats("bp_count", base + 4, 40);
    repeat (3) @(negedge clk);
    check("bp_no_dup", 64'(got_n), 64'(base + 4));
    expect_beat("bp", base + 0, 4'h3, 64'hB000_0000_0000_0000, 2'b00, 1'b0);
    expect_beat("bp", base + 1, 4'h4, 64'hB111_1111_1111_1111, 2'b00, 1'b0);
    expect_beat("bp", base + 2, 4'h5, 64'hB222_2222_2222_2222, 2'b00, 1'b0);
    expect_beat("bp", base + 3, 4'h6, 64'hB333_3333_3333_3333, 2'b00, 1'b1);

    // Masking and response folding (single-beat bursts).
    base = got_n;
    push(4'h7, 1'b1, 2'b01, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 2'b00);
    push(4'h8, 1'b1, 2'b01, 64'h1111_2222_3333_4444, 2'b10, 2'b00);
    push(4'h9, 1'b1, 2'b11, 64'h5555_6666_7777_8888, 2'b10, 2'b00);
    push(4'hA, 1'b1, 2'b11, 64'h9999_AAAA_BBBB_CCCC, 2'b00, 2'b11);
    push(4'hB, 1'b1, 2'b11, 64'hDDDD_EEEE_FFFF_0000, 2'b00, 2'b01);
    push(4'hC, 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 2'b11);
    push(4'hD, 1'b1, 2'b10, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 2'b10);
    wait_beats("mask_count", base + 7, 40);
    expect_beat("mask", base + 0, 4'h7, 64'h0000_0000_CCCC_DDDD, 2'b00, 1'b1);
    expect_beat("resp_err_unsel", base + 1, 4'h8, 64'h0000_0000_3333_4444, 2'b00, 1'b1);
    expect_beat("resp_err_sel", base + 2, 4'h9, 64'h5555_6666_7777_8888, 2'b10, 1'b1);
    expect_beat("resp_exokay", base + 3, 4'hA, 64'h9999_AAAA_BBBB_CCCC, 2'b01, 1'b1);
    expect_beat("resp_partial_exokay", base + 4, 4'hB, 64'hDDDD_EEEE_FFFF_0000, 2'b00, 1'b1);
    expect_beat("sel_none", base + 5, 4'hC, 64'h0, 2'b00, 1'b1);
    expect_beat("mask_hi", base + 6, 4'hD, 64'hAAAA_BBBB_0000_0000, 2'b01, 1'b1);

    // Error inside a burst: sticky build propagates it to the end of the burst.
`ifdef R_PACKER_ERR_STICKY_EN
    sticky_exp = 2'b10;
`else
    sticky_exp = 2'b00;
`endif
    base = got_n;
    push(4'hE, 1'b0, 2'b11, 64'h0000_0000_0000_0010, 2'b00, 2'b00);
    push(4'hE, 1'b0, 2'b11, 64'h0000_0000_0000_0011, 2'b01, 2'b00);
    push(4'hE, 1'b0, 2'b11, 64'h0000_0000_0000_0012, 2'b00, 2'b00);
    push(4'hE, 1'b1, 2'b11, 64'h0000_0000_0000_0013, 2'b00, 2'b00);
    push(4'hF, 1'b0, 2'b11, 64'h0000_0000_0000_0020, 2'b00, 2'b00);
    push(4'hF, 1'b1, 2'b11, 64'h0000_0000_0000_0021, 2'b00, 2'b00);
    wait_beats("sticky_count", base + 6, 40);
    expect_beat("sticky", base + 0, 4'hE, 64'h10, 2'b00, 1'b0);
    expect_beat("sticky", base + 1, 4'hE, 64'h11, 2'b10, 1'b0);
    expect_beat("sticky", base + 2, 4'hE, 64'h12, sticky_exp, 1'b0);
    expect_beat("sticky", base + 3, 4'hE, 64'h13, sticky_exp, 1'b1);
    expect_beat("sticky_next", base + 4, 4'hF, 64'h20, 2'b00, 1'b0);
    expect_beat("sticky_next", base + 5, 4'hF, 64'h21, 2'b00, 1'b1);

    // Response present without meta: neither FIFO may be popped.
    @(negedge clk);
    base        = got_n;
    pops_before = rsp_rd;
    push_rsp(64'h7777_0000_0000_7777, 2'b00, 2'b00);
    repeat (4) @(negedge clk);
    check("meta_empty_rsp_pop", 64'(rsp_pop), 64'd0);
    check("meta_empty_rsp_count", 64'(rsp_rd - pops_before), 64'd0);
    check("meta_empty_meta_count", 64'(meta_rd - pops_before), 64'd0);
    check("meta_empty_valid", 64'(r_valid), 64'd0);
    push_meta(4'h5, 1'b1, 2'b11);
    wait_beats("meta_late_count", base + 1, 20);
    expect_beat("meta_late", base, 4'h5, 64'h7777_0000_0000_7777, 2'b00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
